// File: rtl/rx_buf_pkg.sv
// rx_buf_pkg: shared types and helpers for the RX packet buffer.
//   rxbuf_state_t : write-side FSM states (IDLE / RECV / DROP)
//   DATA_W_DEF    : default byte width
//   ptr_w()       : pointer width for a given depth (one extra wrap bit)
package rx_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rxbuf_state_t;

    localparam int DATA_W_DEF = 8;

    // Pointers carry one bit beyond the address so full and empty differ.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_buf_mem.sv
// rx_buf_mem: DEPTH x DATA_W byte store.
//   clk   in  : write clock
//   we    in  : write enable
//   waddr in  : write address
//   wdata in  : write data
//   raddr in  : read address (asynchronous read)
//   rdata out : contents at raddr
// No reset: the reader never sees a location before it has been written.
module rx_buf_mem
    import rx_buf_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = ptr_w(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_packet_buffer.sv
// rx_packet_buffer: byte store behind the USB receiver control unit.
// Bytes of a packet are written speculatively (wr_ptr) and become visible
// to the reader (cm_ptr) only when rcving falls cleanly. Errored or
// overrun packets are discarded by rolling wr_ptr back to cm_ptr.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   rcving              : packet in flight
//   w_enable, rcv_data  : byte strobe and byte
//   r_error             : receiver error level
//   r_enable            : reader pop request
//   r_data              : head committed byte, first-word-fall-through (0 when empty)
//   empty, full         : no committed bytes / buffer space exhausted (incl. in-flight)
//   byte_count          : committed unread bytes
//   pkt_done            : one-cycle pulse when a non-empty packet commits
//   overrun             : sticky, last packet dropped for lack of space
//   drop_cnt            : saturating dropped-packet count (only with RXBUF_STATS_EN)
// Build option: define RXBUF_STATS_EN to add the drop_cnt output.
module rx_packet_buffer
    import rx_buf_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rcving,
    input  logic                    w_enable,
    input  logic [DATA_W-1:0]       rcv_data,
    input  logic                    r_error,
    input  logic                    r_enable,
    output logic [DATA_W-1:0]       r_data,
    output logic                    empty,
    output logic                    full,
    output logic [ptr_w(DEPTH)-1:0] byte_count,
    output logic                    pkt_done,
`ifdef RXBUF_STATS_EN
    output logic [7:0]              drop_cnt,
`endif
    output logic                    overrun
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    rxbuf_state_t      state_q, state_d;
    logic              rcving_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              pkt_done_q, pkt_done_d;
    logic              overrun_q, overrun_d;
    logic              mem_we;
    logic              drop_evt;
    logic              rcv_rise, rcv_fall;
    logic              empty_w, full_w, pop;
    logic [DATA_W-1:0] mem_rdata;
`ifdef RXBUF_STATS_EN
    logic [7:0]        drop_cnt_q, drop_cnt_d;
`endif

    assign rcv_rise = rcving & ~rcving_q;
    assign rcv_fall = ~rcving & rcving_q;

    // Reader only ever sees committed data; full counts in-flight bytes.
    assign empty_w = (rd_ptr_q == cm_ptr_q);
    assign full_w  = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign pop     = r_enable & ~empty_w;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        pkt_done_d = 1'b0;
        overrun_d  = overrun_q;
        mem_we     = 1'b0;
        drop_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rcv_rise) begin
                    state_d   = RECV;
                    overrun_d = 1'b0;
                end
            end
            RECV: begin
                if (r_error) begin
                    state_d  = DROP;
                    wr_ptr_d = cm_ptr_q;
                    drop_evt = 1'b1;
                end else if (w_enable && full_w) begin
                    state_d   = DROP;
                    wr_ptr_d  = cm_ptr_q;
                    overrun_d = 1'b1;
                    drop_evt  = 1'b1;
                end else begin
                    if (w_enable) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                    // Commit uses wr_ptr_d so a byte on the falling cycle is included.
                    if (rcv_fall) begin
                        state_d    = IDLE;
                        cm_ptr_d   = wr_ptr_d;
                        pkt_done_d = (wr_ptr_d != cm_ptr_q);
                    end
                end
            end
            DROP: begin
                if (!rcving) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RXBUF_STATS_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rcving_q   <= 1'b0;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_done_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef RXBUF_STATS_EN
            drop_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            rcving_q   <= rcving;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_done_q <= pkt_done_d;
            overrun_q  <= overrun_d;
`ifdef RXBUF_STATS_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    rx_buf_mem #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .AW    (AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_ptr_q[AW-1:0]),
        .wdata(rcv_data),
        .raddr(rd_ptr_q[AW-1:0]),
        .rdata(mem_rdata)
    );

    assign r_data     = empty_w ? '0 : mem_rdata;
    assign empty      = empty_w;
    assign full       = full_w;
    assign byte_count = cm_ptr_q - rd_ptr_q;
    assign pkt_done   = pkt_done_q;
    assign overrun    = overrun_q;
`ifdef RXBUF_STATS_EN
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Bench for rx_packet_buffer: one DEPTH=8 and one DEPTH=4 instance share
// the same stimulus; each test checks the instance it is written for.
module tb_rx_packet_buffer;

    logic       clk = 1'b0;
    logic       rst, rcving, w_enable, r_error, r_enable;
    logic [7:0] rcv_data;
    logic [7:0] r_data8, r_data4;
    logic       empty8, full8, pkt_done8, overrun8;
    logic       empty4, full4, pkt_done4, overrun4;
    logic [3:0] byte_count8;
    logic [2:0] byte_count4;
`ifdef RXBUF_STATS_EN
    logic [7:0] drop_cnt8, drop_cnt4;
`endif

    always #5 clk = ~clk;

    rx_packet_buffer #(.DEPTH(8), .DATA_W(8)) u8 (
        .clk(clk), .rst(rst), .rcving(rcving), .w_enable(w_enable),
        .rcv_data(rcv_data), .r_error(r_error), .r_enable(r_enable),
        .r_data(r_data8), .empty(empty8), .full(full8),
        .byte_count(byte_count8), .pkt_done(pkt_done8),
`ifdef RXBUF_STATS_EN
        .drop_cnt(drop_cnt8),
`endif
        .overrun(overrun8)
    );

    rx_packet_buffer #(.DEPTH(4), .DATA_W(8)) u4 (
        .clk(clk), .rst(rst), .rcving(rcving), .w_enable(w_enable),
        .rcv_data(rcv_data), .r_error(r_error), .r_enable(r_enable),
        .r_data(r_data4), .empty(empty4), .full(full4),
        .byte_count(byte_count4), .pkt_done(pkt_done4),
`ifdef RXBUF_STATS_EN
        .drop_cnt(drop_cnt4),
`endif
        .overrun(overrun4)
    );

    typedef struct {
        logic [3:0][7:0] b;
        int              n;
        int              err_at;   // byte index where r_error rises; n = after last byte; -1 = none
        bit              lof;      // last byte arrives on the rcving-fall cycle
        logic [3:0]      exp_cnt;
        bit              exp_done;
    } vec_t;

    vec_t       vecs[7];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    bit         reader_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; in reader mode pop every cycle and score the data.
    task automatic step();
        if (reader_on) begin
            chk("wrap_full", 32'(full8), 32'd0);
            if (!empty8) begin
                if (exp_q.size() == 0) chk("wrap_extra_byte", 32'(r_data8), 32'hFFFF_FFFF);
                else                   chk("wrap_data", 32'(r_data8), 32'(exp_q.pop_front()));
            end
            r_enable = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [3:0][7:0] b, input int n, input int err_at, input bit lof);
        rcving = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            if (i == err_at) r_error = 1'b1;
            w_enable = 1'b1;
            rcv_data = b[i];
            if (lof && i == n - 1) rcving = 1'b0;
            step();
        end
        w_enable = 1'b0;
        if (err_at == n) begin
            r_error = 1'b1;
            step();
        end
        r_error = 1'b0;
        if (rcving) begin
            rcving = 1'b0;
            step();
        end
    endtask

    task automatic drain8();
        for (int g = 0; g < 16 && exp_q.size() > 0; g++) begin
            chk("rd_not_empty", 32'(empty8), 32'd0);
            chk("rd_data", 32'(r_data8), 32'(exp_q.pop_front()));
            r_enable = 1'b1;
            step();
            r_enable = 1'b0;
        end
        chk("rd_empty", 32'(empty8), 32'd1);
        chk("rd_data_zero", 32'(r_data8), 32'd0);
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, "_empty"}, 32'(empty8), 32'd1);
        chk({tag, "_full"}, 32'(full8), 32'd0);
        chk({tag, "_count"}, 32'(byte_count8), 32'd0);
        chk({tag, "_pkt_done"}, 32'(pkt_done8), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun8), 32'd0);
        chk({tag, "_r_data"}, 32'(r_data8), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_q.delete();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][7:0] pb;

        vecs[0] = '{32'h0081_3CA5, 3, -1, 1'b0, 4'd3, 1'b1};
        vecs[1] = '{32'h0000_2211, 2,  2, 1'b0, 4'd0, 1'b0};
        vecs[2] = '{32'h0000_0055, 1, -1, 1'b0, 4'd1, 1'b1};
        vecs[3] = '{32'h007E_0201, 3, -1, 1'b1, 4'd3, 1'b1};
        vecs[4] = '{32'h0000_0000, 0, -1, 1'b0, 4'd0, 1'b0};
        vecs[5] = '{32'h0000_0099, 1,  0, 1'b0, 4'd0, 1'b0};
        vecs[6] = '{32'hDDCC_BBAA, 4, -1, 1'b1, 4'd4, 1'b1};

        rst = 1'b1; rcving = 1'b0; w_enable = 1'b0; r_error = 1'b0;
        r_enable = 1'b0; rcv_data = 8'h00;
        #12;
        chk_reset8("reset");
        chk("reset_empty4", 32'(empty4), 32'd1);
        rst = 1'b0;
        step();

        // Table-driven packets on the DEPTH=8 instance
        foreach (vecs[k]) begin
            send_pkt(vecs[k].b, vecs[k].n, vecs[k].err_at, vecs[k].lof);
            chk("pkt_done", 32'(pkt_done8), 32'(vecs[k].exp_done));
            chk("byte_count", 32'(byte_count8), 32'(vecs[k].exp_cnt));
            if (vecs[k].exp_done)
                for (int i = 0; i < vecs[k].n; i++) exp_q.push_back(vecs[k].b[i]);
            step();
            chk("pkt_done_pulse", 32'(pkt_done8), 32'd0);
            drain8();
        end
`ifdef RXBUF_STATS_EN
        chk("drop_cnt", 32'(drop_cnt8), 32'd2);
`endif

        // Overrun on DEPTH=4 with a committed packet already waiting
        do_reset();
        send_pkt(32'h0000_C2C1, 2, -1, 1'b0);
        chk("t3_count", 32'(byte_count4), 32'd2);
        rcving = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            w_enable = 1'b1;
            rcv_data = 8'hE0 + 8'(i);
            step();
            if (i == 1) chk("t3_full", 32'(full4), 32'd1);
        end
        w_enable = 1'b0;
        rcving = 1'b0;
        step();
        chk("t3_overrun", 32'(overrun4), 32'd1);
        chk("t3_no_pkt_done", 32'(pkt_done4), 32'd0);
        chk("t3_count_kept", 32'(byte_count4), 32'd2);
        chk("t3_full_clear", 32'(full4), 32'd0);
        chk("t3_rd0", 32'(r_data4), 32'hC1);
        r_enable = 1'b1; step(); r_enable = 1'b0;
        chk("t3_rd1", 32'(r_data4), 32'hC2);
        r_enable = 1'b1; step(); r_enable = 1'b0;
        chk("t3_empty", 32'(empty4), 32'd1);
        rcving = 1'b1;
        step();
        chk("t3_overrun_clear", 32'(overrun4), 32'd0);
        rcving = 1'b0;
        step();

        // Pointer wrap on DEPTH=8 with a reader popping every cycle
        do_reset();
        reader_on = 1'b1;
        for (int p = 0; p < 20; p++) begin
            pb = '0;
            for (int i = 0; i < 3; i++) pb[i] = 8'(p * 3 + i + 1);
            send_pkt(pb, 3, -1, 1'b0);
            for (int i = 0; i < 3; i++) exp_q.push_back(pb[i]);
        end
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) step();
        reader_on = 1'b0;
        r_enable = 1'b0;
        chk("wrap_leftover", 32'(exp_q.size()), 32'd0);
        step();
        chk("wrap_empty", 32'(empty8), 32'd1);

        // Reset in the middle of a packet
        do_reset();
        rcving = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            w_enable = 1'b1;
            rcv_data = 8'h30 + 8'(i);
            step();
        end
        w_enable = 1'b0;
        rcving = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset8("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        step();
        send_pkt(32'h0000_6B5A, 2, -1, 1'b0);
        chk("t6_pkt_done", 32'(pkt_done8), 32'd1);
        chk("t6_count", 32'(byte_count8), 32'd2);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h6B);
        step();
        drain8();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
